// File: rtl/ready_bits_scoreboard_if.sv
// ready_bits_scoreboard_if: issue/writeback/retire request bundle and registered table outputs of the ready-bits scoreboard.
interface ready_bits_scoreboard_if #(
    parameter int INFO_LENGTH   = 8,
    parameter int NUM_WF        = 40,
    parameter int WF_ID_LENGTH  = 6,
    parameter int NUM_CLR_PORTS = 2
) ();
    logic                                   set_en;
    logic [WF_ID_LENGTH-1:0]                set_wfid;
    logic [INFO_LENGTH-1:0]                 set_bits;
    logic [NUM_CLR_PORTS-1:0]               clr_en;
    logic [NUM_CLR_PORTS*WF_ID_LENGTH-1:0]  clr_wfid;
    logic [NUM_CLR_PORTS*INFO_LENGTH-1:0]   clr_bits;
    logic                                   retire_en;
    logic [WF_ID_LENGTH-1:0]                retire_wfid;
    logic [INFO_LENGTH*NUM_WF-1:0]          bits_out;
    logic [NUM_WF-1:0]                      slot_busy;
    logic                                   set_conflict;
    logic                                   id_err;
    modport master (
        output set_en, set_wfid, set_bits, clr_en, clr_wfid, clr_bits, retire_en, retire_wfid,
        input  bits_out, slot_busy, set_conflict, id_err
    );
    modport slave (
        input  set_en, set_wfid, set_bits, clr_en, clr_wfid, clr_bits, retire_en, retire_wfid,
        output bits_out, slot_busy, set_conflict, id_err
    );
endinterface

// File: rtl/ready_bits_scoreboard.sv
// ready_bits_scoreboard: registered per-wavefront ready-bits table with one set port, multiple clear ports and slot retire.
module ready_bits_scoreboard #(
    parameter int INFO_LENGTH   = 8,
    parameter int NUM_WF        = 40,
    parameter int WF_ID_LENGTH  = 6,
    parameter int NUM_CLR_PORTS = 2
) (
    input logic clk,
    input logic rst,
    ready_bits_scoreboard_if.slave bus
);
    logic [NUM_WF-1:0][INFO_LENGTH-1:0] slot_d, slot_q, set_mask, clr_mask;
    logic [NUM_WF-1:0]                  retire_hit, busy_d, busy_q;
    logic [NUM_CLR_PORTS-1:0]           clr_ok;
    logic                               set_ok, retire_ok;
    logic                               conflict_d, conflict_q, id_err_d, id_err_q;

    function automatic logic in_range(input logic [WF_ID_LENGTH-1:0] id);
        return {1'b0, id} < (WF_ID_LENGTH+1)'(NUM_WF);
    endfunction

    // Out-of-range requests are dropped here so they never reach the table.
    always_comb begin
        set_ok    = bus.set_en && in_range(bus.set_wfid);
        retire_ok = bus.retire_en && in_range(bus.retire_wfid);
        for (int p = 0; p < NUM_CLR_PORTS; p++)
            clr_ok[p] = bus.clr_en[p] && in_range(bus.clr_wfid[p*WF_ID_LENGTH +: WF_ID_LENGTH]);
        id_err_d = (bus.set_en && !set_ok) || (bus.retire_en && !retire_ok) || |(bus.clr_en & ~clr_ok);
    end

    always_comb begin
        for (int w = 0; w < NUM_WF; w++) begin
            logic [INFO_LENGTH-1:0] m;
            m = '0;
            for (int p = 0; p < NUM_CLR_PORTS; p++)
                m = m | ((clr_ok[p] && bus.clr_wfid[p*WF_ID_LENGTH +: WF_ID_LENGTH] == WF_ID_LENGTH'(w))
                         ? bus.clr_bits[p*INFO_LENGTH +: INFO_LENGTH] : '0);
            clr_mask[w]   = m;
            set_mask[w]   = (set_ok && bus.set_wfid == WF_ID_LENGTH'(w)) ? bus.set_bits : '0;
            retire_hit[w] = retire_ok && bus.retire_wfid == WF_ID_LENGTH'(w);
        end
    end

    // Set is OR-ed after the clear so a fresh issue beats an older writeback on the same bit.
    always_comb begin
        conflict_d = 1'b0;
        for (int w = 0; w < NUM_WF; w++) begin
            slot_d[w]  = retire_hit[w] ? '0 : ((slot_q[w] & ~clr_mask[w]) | set_mask[w]);
            busy_d[w]  = |slot_d[w];
            conflict_d = conflict_d | (!retire_hit[w] && |(slot_q[w] & set_mask[w] & ~clr_mask[w]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            busy_q     <= '0;
            conflict_q <= 1'b0;
            id_err_q   <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
            id_err_q   <= id_err_d;
        end
    end

    assign bus.bits_out     = slot_q;
    assign bus.slot_busy    = busy_q;
    assign bus.set_conflict = conflict_q;
    assign bus.id_err       = id_err_q;
endmodule

// File: tb/tb_ready_bits_scoreboard.sv
// tb_ready_bits_scoreboard: directed stimulus against a request-ordered behavioural table model, plus literal spot checks.
module tb_ready_bits_scoreboard;
    localparam int I = 8;
    localparam int N = 40;
    localparam int W = 6;
    localparam int P = 2;

    typedef logic [I-1:0] tbl_t [N];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    tbl_t model;
    logic exp_conf, exp_err;

    ready_bits_scoreboard_if #(.INFO_LENGTH(I), .NUM_WF(N), .WF_ID_LENGTH(W), .NUM_CLR_PORTS(P)) bus ();

    ready_bits_scoreboard #(.INFO_LENGTH(I), .NUM_WF(N), .WF_ID_LENGTH(W), .NUM_CLR_PORTS(P)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int cid(int p);
        return int'(bus.clr_wfid[p*W +: W]);
    endfunction

    function automatic logic [I-1:0] cbits(int p);
        return bus.clr_bits[p*I +: I];
    endfunction

    // Model applies writebacks, then the issue, then the retire: later operations override earlier ones.
    function automatic tbl_t next_tbl(tbl_t cur);
        tbl_t n = cur;
        for (int p = 0; p < P; p++)
            if (bus.clr_en[p] && cid(p) < N) n[cid(p)] = n[cid(p)] & ~cbits(p);
        if (bus.set_en && int'(bus.set_wfid) < N) n[int'(bus.set_wfid)] = n[int'(bus.set_wfid)] | bus.set_bits;
        if (bus.retire_en && int'(bus.retire_wfid) < N) n[int'(bus.retire_wfid)] = '0;
        return n;
    endfunction

    function automatic logic calc_conf(tbl_t cur);
        int s = int'(bus.set_wfid);
        logic [I-1:0] cleared = '0;
        if (!bus.set_en || s >= N) return 1'b0;
        if (bus.retire_en && int'(bus.retire_wfid) == s) return 1'b0;
        for (int p = 0; p < P; p++)
            if (bus.clr_en[p] && cid(p) == s) cleared = cleared | cbits(p);
        return (cur[s] & bus.set_bits & ~cleared) != '0;
    endfunction

    function automatic logic calc_err();
        logic e = (bus.set_en && int'(bus.set_wfid) >= N) || (bus.retire_en && int'(bus.retire_wfid) >= N);
        for (int p = 0; p < P; p++)
            if (bus.clr_en[p] && cid(p) >= N) e = 1'b1;
        return e;
    endfunction

    function automatic logic [I*N-1:0] flat(tbl_t t);
        logic [I*N-1:0] v = '0;
        for (int w = 0; w < N; w++) v[w*I +: I] = t[w];
        return v;
    endfunction

    function automatic logic [N-1:0] busy(tbl_t t);
        logic [N-1:0] v = '0;
        for (int w = 0; w < N; w++) v[w] = t[w] != '0;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < N; w++) model[w] <= '0;
            exp_conf <= 1'b0;
            exp_err  <= 1'b0;
        end else begin
            model    <= next_tbl(model);
            exp_conf <= calc_conf(model);
            exp_err  <= calc_err();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks = checks + 4;
            if (bus.bits_out !== flat(model)) begin
                errors++;
                $display("FAIL bits_out got %h want %h", bus.bits_out, flat(model));
            end
            if (bus.slot_busy !== busy(model)) begin
                errors++;
                $display("FAIL slot_busy got %h want %h", bus.slot_busy, busy(model));
            end
            if (bus.set_conflict !== exp_conf) begin
                errors++;
                $display("FAIL set_conflict got %b want %b", bus.set_conflict, exp_conf);
            end
            if (bus.id_err !== exp_err) begin
                errors++;
                $display("FAIL id_err got %b want %b", bus.id_err, exp_err);
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.set_en = 1'b0; bus.set_wfid = '0; bus.set_bits = '0;
        bus.clr_en = '0; bus.clr_wfid = '0; bus.clr_bits = '0;
        bus.retire_en = 1'b0; bus.retire_wfid = '0;
    endtask

    task automatic set_req(int id, logic [I-1:0] b);
        bus.set_en = 1'b1; bus.set_wfid = W'(id); bus.set_bits = b;
    endtask

    task automatic clr_req(int p, int id, logic [I-1:0] b);
        bus.clr_en[p] = 1'b1; bus.clr_wfid[p*W +: W] = W'(id); bus.clr_bits[p*I +: I] = b;
    endtask

    task automatic go();
        @(negedge clk);
        idle();
    endtask

    function automatic logic [I-1:0] slot(int w);
        return bus.bits_out[w*I +: I];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        repeat (2) @(negedge clk);
        chk("reset_bits", 64'(bus.bits_out != '0), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(bus.slot_busy), 0);

        set_req(5, 8'hF0); go();
        chk("wf5_set", slot(5), 8'hF0);
        chk("wf5_busy", bus.slot_busy[5], 1);
        clr_req(0, 5, 8'h30); go();
        chk("wf5_clr", slot(5), 8'hC0);
        chk("wf5_busy2", bus.slot_busy[5], 1);
        clr_req(0, 5, 8'hC0); go();
        chk("wf5_empty", slot(5), 8'h00);
        chk("wf5_idle", bus.slot_busy[5], 0);

        set_req(39, 8'h01); go();
        set_req(39, 8'h01); clr_req(0, 39, 8'h01); clr_req(1, 39, 8'h02); go();
        chk("wf39_simul", slot(39), 8'h01);
        chk("wf39_noconf", bus.set_conflict, 0);
        set_req(39, 8'h01); go();
        chk("wf39_conf", bus.set_conflict, 1);
        chk("wf39_keep", slot(39), 8'h01);
        go();
        chk("wf39_conf_pulse", bus.set_conflict, 0);

        set_req(0, 8'hFF); go();
        clr_req(0, 0, 8'h0F); clr_req(1, 0, 8'hF0); go();
        chk("wf0_multiclr", slot(0), 8'h00);
        chk("wf0_noerr", bus.id_err, 0);

        set_req(10, 8'hAA); go();
        set_req(10, 8'h55); bus.retire_en = 1'b1; bus.retire_wfid = W'(10); go();
        chk("wf10_retire", slot(10), 8'h00);
        chk("wf10_noconf", bus.set_conflict, 0);
        chk("wf39_untouched", slot(39), 8'h01);

        set_req(2, 8'h0F); go();
        set_req(40, 8'hFF); clr_req(0, 2, 8'h0F); go();
        chk("wf2_cleared", slot(2), 8'h00);
        chk("oor_set_err", bus.id_err, 1);
        chk("oor_set_busy", 64'(bus.slot_busy), 64'(1) << 39);
        go();
        chk("oor_err_pulse", bus.id_err, 0);
        clr_req(1, 63, 8'hFF); set_req(3, 8'h81); go();
        chk("oor_clr_err", bus.id_err, 1);
        chk("wf3_set", slot(3), 8'h81);
        bus.retire_en = 1'b1; bus.retire_wfid = W'(50); go();
        chk("oor_ret_err", bus.id_err, 1);
        chk("wf3_kept", slot(3), 8'h81);

        #2 rst = 1'b1;
        #1;
        chk("async_bits", 64'(bus.bits_out != '0), 0);
        chk("async_busy", 64'(bus.slot_busy), 0);
        set_req(8, 8'hFF);
        @(negedge clk);
        idle();
        set_req(7, 8'h11);
        rst = 1'b0;
        go();
        chk("post_rst_wf7", slot(7), 8'h11);
        chk("post_rst_wf8", slot(8), 8'h00);
        chk("post_rst_wf39", slot(39), 8'h00);
        go();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
